button_debounce: RTL
====================

// Module: button_debounce
//
// PURPOSE
//  Input-side companion to the LED output drivers: samples the board pushbuttons.
//  Each button is synchronised to clk, debounced, and turned into a stable level,
//  one-cycle press/release pulses, and a press-toggled bit that can drive an LED.
//  Sits between the raw button pins (icestick PMOD, Icezum SW1/SW2) and user logic.
//
// PARAMETERS
//  N_BTN      2       number of independent button channels
//  DB_CYCLES  120000  stable cycles needed to accept a change (10 ms @ 12 MHz); >= 2
//  ACTIVE_LOW 0       1: raw pin reads 0 when pressed (inverted after synchroniser)
//
// PORTS
//  clk          in   1      system clock (12 MHz on target boards)
//  rstn         in   1      asynchronous active-low reset
//  btn_raw      in   N_BTN  raw, asynchronous button pins
//  btn_level    out  N_BTN  debounced level, 1 = pressed
//  btn_press    out  N_BTN  1-cycle pulse on accepted 0->1 of btn_level
//  btn_release  out  N_BTN  1-cycle pulse on accepted 1->0 of btn_level
//  btn_toggle   out  N_BTN  flips on every btn_press (LED-ready)
//
// BEHAVIOUR
//  - Reset (rstn=0, async): sync flops, counters, btn_level, btn_press, btn_release,
//    btn_toggle all 0. Sync flops reset to the "released" value (ACTIVE_LOW applied).
//  - Sync: 2-FF synchroniser per channel; ACTIVE_LOW inversion after 2nd flop -> s.
//  - Counter cnt, width CW = $clog2(DB_CYCLES), saturates, never wraps:
//      s == btn_level            : cnt <= 0
//      s != btn_level, cnt < DB_CYCLES-1 : cnt <= cnt+1
//      s != btn_level, cnt == DB_CYCLES-1: btn_level <= s; cnt <= 0; pulse
//  - Pulses: btn_press/btn_release are registered; high exactly the cycle btn_level
//    takes its new value. Never both high on one channel.
//  - Toggle: btn_toggle <= ~btn_toggle in the same cycle btn_press is asserted.
//  - Latency: raw edge -> btn_level change = 2 (sync) + DB_CYCLES clk cycles,
//    given the input stays stable throughout.
//  - Glitch: any return of s to btn_level before terminal count clears cnt; no
//    output change and no pulse. Bounce restarts the full DB_CYCLES window.
//  - Channels fully independent; simultaneous presses on several channels give
//    simultaneous pulses.
//  - Button held across reset release: btn_level starts 0, press reported after
//    2 + DB_CYCLES cycles (no suppression).
//  - Reset mid-count: count discarded; no pulse emitted on reset entry or exit.
//
// STRUCTURE
//  - Shared header btn_defs.vh: default DB_CYCLES for 12 MHz (DB_10MS_12MHZ),
//    sim value DB_SIM = 8, RELEASED/PRESSED level constants.
//  - Sub-module debounce_channel (1 bit: sync, counter, level, pulses, toggle);
//    button_debounce instantiates N_BTN copies in a generate loop.
//
// TESTING  (DB_CYCLES=8, N_BTN=2, ACTIVE_LOW=0)
//  1 Reset: rstn=0 with btn_raw=2'b11 -> all outputs 0 immediately, held while rstn=0.
//  2 Clean press: btn_raw[0] 0->1, held -> btn_level[0]=1 and btn_press[0]=1 for one
//    cycle exactly 10 cycles later; btn_toggle[0]=1; channel 1 unchanged.
//  3 Bounce: btn_raw[0] high 5 cycles, low 1, high 20 -> no output during the bounce;
//    a single btn_press, 10 cycles after the final rising edge.
//  4 Release: after 2, drop btn_raw[0] -> btn_release[0] pulse at +10, level 0,
//    toggle stays 1; a second press -> toggle 0.
//  5 Simultaneous: both bits rise together -> both btn_press in the same cycle.
//  6 Reset mid-count: raise btn_raw[1], assert rstn at cycle 5 for 3 cycles, keep
//    pressed -> no pulse during reset; btn_press[1] 10 cycles after rstn rises.
//    Repeat with ACTIVE_LOW=1 and inverted stimulus -> identical outputs.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared constants for the pushbutton front end: default debounce windows and
// the logical button levels used after any active-low inversion.
package button_debounce_pkg;

   localparam int unsigned DB_10MS_12MHZ = 120000;  // 10 ms at 12 MHz
   localparam int unsigned DB_SIM        = 8;       // short window for simulation

   localparam logic RELEASED = 1'b0;
   localparam logic PRESSED  = 1'b1;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: 2-FF synchroniser, saturating stability counter,
// debounced level, registered press/release pulses and a press-toggled bit.
module button_debounce_channel
   import button_debounce_pkg::*;
#(
   parameter int unsigned DB_CYCLES  = DB_10MS_12MHZ,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic toggle_o
);

   localparam int unsigned    CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_TERM = CW'(DB_CYCLES - 1);
   localparam logic           RAW_IDLE = RELEASED ^ ACTIVE_LOW;

   logic          sync1_q, sync2_q;
   logic          s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          toggle_q, toggle_d;

   // Synchroniser idles at the pin's released value so reset exit looks like no press.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= RAW_IDLE;
         sync2_q <= RAW_IDLE;
      end else begin
         // NOTE: non-blocking assignments keep the two flops a true two-stage shift.
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q ^ ACTIVE_LOW;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      toggle_d  = toggle_q;
      if (s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TERM) begin
         cnt_d     = '0;
         level_d   = s;
         press_d   = (s == PRESSED);
         release_d = (s == RELEASED);
         toggle_d  = toggle_q ^ (s == PRESSED);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         level_q   <= RELEASED;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         toggle_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         toggle_q  <= toggle_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign toggle_o  = toggle_q;

endmodule

// File: rtl/button_debounce.sv
// Board pushbutton front end: N_BTN independent debounce channels between the
// raw button pins and user logic.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int unsigned N_BTN      = 2,
   parameter int unsigned DB_CYCLES  = DB_10MS_12MHZ,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_toggle
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_debounce_channel #(
         .DB_CYCLES  (DB_CYCLES),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .rstn      (rstn),
         .raw_i     (btn_raw[i]),
         .level_o   (btn_level[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i]),
         .toggle_o  (btn_toggle[i])
      );
   end

endmodule
